// File: rtl/write_bank_pkg.sv
// Shared types and constants for the write_bank output buffer.
package write_bank_pkg;

   localparam int BYTES_PER_WORD = 8;

   typedef enum logic [2:0] {
      S_FILL,
      S_FLUSH,
      S_RD,
      S_LOAD,
      S_OUT,
      S_DONE
   } state_t;

   // MSB-first mask with the top n_bytes bits set (3 -> 8'hE0).
   function automatic logic [7:0] head_mask(input logic [2:0] n_bytes);
      return ~(8'hFF >> n_bytes);
   endfunction

endpackage

// File: rtl/single_ram.sv
// Single-port RAM with registered read; one instance per lane holds packed 64-bit words.
module Single_RAM #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; the write pointer alone defines what is valid.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
   end

endmodule

// File: rtl/write_bank_lane_packer.sv
// Per-lane pack register: beat k lands in bits [63-8k -: 8]; unwritten bytes stay zero.
module lane_packer
   import write_bank_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_clear,
   input  logic [2:0]  i_pos,
   input  logic [7:0]  i_byte,
   output logic [63:0] o_word,
   output logic [63:0] o_padded
);

   logic [63:0] r_pack;
   logic [63:0] w_merged;

   // NOTE: default assignment first so the partial update cannot infer a latch.
   always_comb begin
      w_merged = r_pack;
      w_merged[(BYTES_PER_WORD - 1 - int'(i_pos)) * 8 +: 8] = i_byte;
   end

   // Clear wins over load: the completing beat is consumed through o_word.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_pack <= '0;
      end else if (i_load) begin
         r_pack <= w_merged;
      end
   end

   assign o_word   = w_merged;
   assign o_padded = r_pack;

endmodule

// File: rtl/write_bank.sv
// Output-side byte packer and drain engine for the FPU array.
// Optional WRITE_BANK_BYTE_MASK_EN adds out_mask, the MSB-first valid-byte mask of data_out.
module write_bank
   import write_bank_pkg::*;
#(
   parameter  int BANK_WIDTH             = 10,
   parameter  int MEM_BUFFER_DEPTH_BYTES = 512,
   localparam int DEPTH_WORDS            = MEM_BUFFER_DEPTH_BYTES / BYTES_PER_WORD,
   localparam int LANE_W                 = $clog2(BANK_WIDTH),
   localparam int ADDR_W                 = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        data_in [BANK_WIDTH],
   input  logic              drain_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       data_out,
   output logic [LANE_W-1:0] out_lane,
   output logic [ADDR_W-1:0] out_addr,
   output logic              drain_done,
   output logic              busy
`ifdef WRITE_BANK_BYTE_MASK_EN
   ,
   output logic [7:0]        out_mask
`endif
);

   state_t            r_state;
   logic [2:0]        r_byte_cnt;
   logic [ADDR_W:0]   r_wr_word;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [LANE_W-1:0] r_rd_lane;

   logic              w_accept;
   logic              w_word_done;
   logic              w_we;
   logic [2:0]        w_cnt_after;
   logic [ADDR_W:0]   w_wr_after;
   logic [ADDR_W-1:0] w_ram_addr;
   logic              w_last_word;
   logic              w_last;

   logic [63:0]       w_full  [BANK_WIDTH];
   logic [63:0]       w_pad   [BANK_WIDTH];
   logic [63:0]       w_din   [BANK_WIDTH];
   logic [63:0]       w_rdata [BANK_WIDTH];

   assign in_ready    = (r_state == S_FILL) && (r_wr_word < (ADDR_W + 1)'(DEPTH_WORDS));
   assign busy        = (r_state != S_FILL);
   assign w_accept    = in_valid && in_ready;
   assign w_word_done = w_accept && (r_byte_cnt == 3'd7);
   // 3-bit count wraps 7 -> 0 exactly when a word completes.
   assign w_cnt_after = w_accept ? r_byte_cnt + 3'd1 : r_byte_cnt;
   assign w_wr_after  = w_word_done ? r_wr_word + (ADDR_W + 1)'(1) : r_wr_word;
   assign w_we        = w_word_done || (r_state == S_FLUSH);
   assign w_ram_addr  = (r_state == S_RD) ? r_rd_addr : r_wr_word[ADDR_W-1:0];
   assign w_last_word = ((ADDR_W + 1)'(r_rd_addr) + (ADDR_W + 1)'(1)) == r_wr_word;
   assign w_last      = w_last_word && (r_rd_lane == LANE_W'(BANK_WIDTH - 1));

   for (genvar g = 0; g < BANK_WIDTH; g++) begin : g_lane
      lane_packer u_pack (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_load   (w_accept),
         .i_clear  (w_we),
         .i_pos    (r_byte_cnt),
         .i_byte   (data_in[g]),
         .o_word   (w_full[g]),
         .o_padded (w_pad[g])
      );

      assign w_din[g] = (r_state == S_FLUSH) ? w_pad[g] : w_full[g];

      Single_RAM #(
         .DEPTH (DEPTH_WORDS),
         .WIDTH (64)
      ) u_ram (
         .clk  (clk),
         .we   (w_we),
         .addr (w_ram_addr),
         .din  (w_din[g]),
         .dout (w_rdata[g])
      );
   end

   // NOTE: all state and registered outputs use non-blocking assignment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_FILL;
         r_byte_cnt <= '0;
         r_wr_word  <= '0;
         r_rd_addr  <= '0;
         r_rd_lane  <= '0;
         out_valid  <= 1'b0;
         data_out   <= '0;
         out_lane   <= '0;
         out_addr   <= '0;
         drain_done <= 1'b0;
      end else begin
         drain_done <= 1'b0;
         case (r_state)
            S_FILL: begin
               r_byte_cnt <= w_cnt_after;
               r_wr_word  <= w_wr_after;
               if (drain_req) begin
                  if (w_cnt_after != 3'd0) begin
                     r_state <= S_FLUSH;
                  end else if (w_wr_after == '0) begin
                     r_state    <= S_DONE;
                     drain_done <= 1'b1;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_FLUSH: begin
               r_wr_word  <= r_wr_word + (ADDR_W + 1)'(1);
               r_byte_cnt <= '0;
               r_state    <= S_RD;
            end
            S_RD: r_state <= S_LOAD;
            S_LOAD: begin
               data_out  <= w_rdata[r_rd_lane];
               out_lane  <= r_rd_lane;
               out_addr  <= r_rd_addr;
               out_valid <= 1'b1;
               r_state   <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (w_last) begin
                     r_state    <= S_DONE;
                     drain_done <= 1'b1;
                  end else begin
                     if (r_rd_lane == LANE_W'(BANK_WIDTH - 1)) begin
                        r_rd_lane <= '0;
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                     end else begin
                        r_rd_lane <= r_rd_lane + LANE_W'(1);
                     end
                     r_state <= S_RD;
                  end
               end
            end
            S_DONE: begin
               r_wr_word <= '0;
               r_rd_addr <= '0;
               r_rd_lane <= '0;
               r_state   <= S_FILL;
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

`ifdef WRITE_BANK_BYTE_MASK_EN
   logic [7:0] r_flush_mask;
   logic       r_flushed;

   // Only the final word address can be partial, so one mask register suffices.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flush_mask <= '0;
         r_flushed    <= 1'b0;
         out_mask     <= '0;
      end else begin
         case (r_state)
            S_FLUSH: begin
               r_flush_mask <= head_mask(r_byte_cnt);
               r_flushed    <= 1'b1;
            end
            S_LOAD:  out_mask  <= (r_flushed && w_last_word) ? r_flush_mask : 8'hFF;
            S_DONE:  r_flushed <= 1'b0;
            default: ;
         endcase
      end
   end
`else
   // Without the mask, zero padding of a flushed word is indistinguishable from data.
`endif

endmodule

// File: tb/tb_write_bank.sv
// Self-checking bench for write_bank: vector table, directed corner sequences, and randomized
// fills checked against a byte-queue reference model.
module tb_write_bank;

   localparam int BW        = 10;
   localparam int MAX_BYTES = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  data_in [BW];
   logic        drain_req = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] data_out;
   logic [3:0]  out_lane;
   logic [5:0]  out_addr;
   logic        drain_done;
   logic        busy;
`ifdef WRITE_BANK_BYTE_MASK_EN
   logic [7:0]  out_mask;
`endif

   always #5 clk = ~clk;

   write_bank dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .drain_req  (drain_req),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .out_lane   (out_lane),
      .out_addr   (out_addr),
      .drain_done (drain_done),
      .busy       (busy)
`ifdef WRITE_BANK_BYTE_MASK_EN
      ,
      .out_mask   (out_mask)
`endif
   );

   // Reference model: bytes received per lane, expanded into expected words at drain time.
   typedef struct {
      int          addr;
      int          lane;
      logic [63:0] data;
      logic [7:0]  mask;
   } word_t;

   typedef struct {
      int          n;
      logic [63:0] beats;
      logic [63:0] exp_word;
      logic [7:0]  exp_mask;
   } vec_t;

   logic [7:0]  lane_mem [BW][MAX_BYTES];
   int          model_len = 0;
   word_t       exp_q[$];
   logic [7:0]  beat_buf [BW];

   int          checks = 0;
   int          errors = 0;
   int          last_got;
   logic [63:0] first_data;
   logic [7:0]  first_mask;
   logic [63:0] lane1_addr0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      model_len = 0;
      exp_q.delete();
   endtask

   task automatic build_expected();
      int    nwords;
      int    idx;
      word_t w;
      nwords = (model_len + 7) / 8;
      for (int a = 0; a < nwords; a++) begin
         for (int l = 0; l < BW; l++) begin
            w.addr = a;
            w.lane = l;
            w.data = '0;
            w.mask = '0;
            for (int k = 0; k < 8; k++) begin
               idx    = 8 * a + k;
               w.data = {w.data[55:0], (idx < model_len) ? lane_mem[l][idx] : 8'h00};
               w.mask = {w.mask[6:0], (idx < model_len)};
            end
            exp_q.push_back(w);
         end
      end
      model_len = 0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      drain_req = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_clear();
   endtask

   // Offers beat_buf as one beat; drain_req rides along only on the accepting cycle.
   task automatic push_beat(input bit with_drain);
      int wait_n = 0;
      for (int l = 0; l < BW; l++) data_in[l] = beat_buf[l];
      in_valid  = 1'b1;
      drain_req = 1'b0;
      while (!in_ready && wait_n < 50) begin
         tick();
         wait_n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", in_ready, 1'b1);
      end else begin
         drain_req = with_drain;
         for (int l = 0; l < BW; l++) lane_mem[l][model_len] = beat_buf[l];
         model_len++;
      end
      tick();
      in_valid  = 1'b0;
      drain_req = 1'b0;
      if (with_drain) build_expected();
   endtask

   task automatic drain_only();
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      build_expected();
   endtask

   // Consumes the drain with random backpressure; word stall_word is held off for 5 cycles.
   task automatic collect(input int stall_word);
      int          cyc = 0;
      int          got = 0;
      int          stall = 0;
      int          n_exp;
      bit          done = 1'b0;
      bit          prev_hold = 1'b0;
      bit          last_acc = 1'b0;
      logic [63:0] h_data;
      logic [3:0]  h_lane;
      logic [5:0]  h_addr;
      word_t       e;
      n_exp = exp_q.size();
      while (!done && cyc < 20000) begin
         if (prev_hold) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", data_out, h_data);
            check("hold_lane", out_lane, h_lane);
            check("hold_addr", out_addr, h_addr);
         end
         if (drain_done) begin
            check("done_early", exp_q.size(), 0);
            if (n_exp == 0) check("empty_done_latency", cyc <= 1, 1'b1);
            done = 1'b1;
         end else if (out_valid) begin
            if (got == stall_word && stall < 5) begin
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_word", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("word_data", data_out, e.data);
                  check("word_lane", out_lane, e.lane);
                  check("word_addr", out_addr, e.addr);
`ifdef WRITE_BANK_BYTE_MASK_EN
                  check("word_mask", out_mask, e.mask);
`endif
                  if (got == 0) begin
                     first_data = data_out;
                     first_mask = e.mask;
`ifdef WRITE_BANK_BYTE_MASK_EN
                     first_mask = out_mask;
`endif
                  end
                  if (e.lane == 1 && e.addr == 0) lane1_addr0 = data_out;
                  if (exp_q.size() == 0) last_acc = 1'b1;
               end
               got++;
            end
            prev_hold = !out_ready;
            h_data    = data_out;
            h_lane    = out_lane;
            h_addr    = out_addr;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            prev_hold = 1'b0;
         end
         tick();
         cyc++;
         if (last_acc) begin
            check("drain_done_pulse", drain_done, 1'b1);
            last_acc = 1'b0;
         end
      end
      out_ready = 1'b0;
      if (!done) check("drain_timeout", 1'b0, 1'b1);
      check("word_count", got, n_exp);
      last_got = got;
      tick();
      check("done_one_cycle", drain_done, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("in_ready_idle", in_ready, 1'b1);
   endtask

   vec_t vecs[6];

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int budget;
      int n;
      bit d;

      for (int l = 0; l < BW; l++) data_in[l] = 8'h00;

      vecs[0] = '{3, 64'hAABBCC0000000000, 64'hAABBCC0000000000, 8'hE0};
      vecs[1] = '{1, 64'h5A00000000000000, 64'h5A00000000000000, 8'h80};
      vecs[2] = '{7, 64'h0102030405060700, 64'h0102030405060700, 8'hFE};
      vecs[3] = '{8, 64'hF0F1F2F3F4F5F6F7, 64'hF0F1F2F3F4F5F6F7, 8'hFF};
      vecs[4] = '{0, 64'h0,                64'h0,                8'h00};
      vecs[5] = '{6, 64'h1112131415160000, 64'h1112131415160000, 8'hFC};

      // Reset state
      do_reset();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_drain_done", drain_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data_out", data_out, 64'h0);
      check("rst_out_lane", out_lane, 4'h0);
      check("rst_out_addr", out_addr, 6'h0);
`ifdef WRITE_BANK_BYTE_MASK_EN
      check("rst_out_mask", out_mask, 8'h00);
`endif

      // Full word: lane i byte = 8'h10*i + k
      for (int k = 0; k < 8; k++) begin
         for (int l = 0; l < BW; l++) beat_buf[l] = 8'(8'h10 * l + k);
         push_beat(1'b0);
      end
      drain_only();
      check("busy_draining", busy, 1'b1);
      collect(-1);
      check("lane1_word", lane1_addr0, 64'h1011121314151617);
      check("full_word_count", last_got, 10);

      // Vector table: partial words on all lanes, drain alternately with/after the last beat
      for (int i = 0; i < 6; i++) begin
         do_reset();
         n = vecs[i].n;
         for (int k = 0; k < n; k++) begin
            for (int l = 0; l < BW; l++) beat_buf[l] = vecs[i].beats[63 - 8 * k -: 8];
            push_beat((i % 2 == 0) && (k == n - 1));
         end
         if (!((i % 2 == 0) && n > 0)) drain_only();
         collect(-1);
         check("tbl_count", last_got, (n > 0) ? 10 : 0);
         if (n > 0) begin
            check("tbl_word", first_data, vecs[i].exp_word);
`ifdef WRITE_BANK_BYTE_MASK_EN
            check("tbl_mask", first_mask, vecs[i].exp_mask);
`endif
         end
      end

      // Empty drain straight after reset
      do_reset();
      drain_only();
      collect(-1);
      check("empty_count", last_got, 0);

      // Fill to capacity, confirm refusal, then drain all 640 words with a 5-cycle stall
      do_reset();
      for (int b = 0; b < MAX_BYTES; b++) begin
         for (int l = 0; l < BW; l++) beat_buf[l] = 8'($urandom_range(0, 255));
         push_beat(1'b0);
      end
      check("full_in_ready", in_ready, 1'b0);
      check("full_busy", busy, 1'b0);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int l = 0; l < BW; l++) data_in[l] = 8'($urandom_range(0, 255));
         tick();
         check("full_refuse", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      drain_only();
      collect(7);
      check("full_count", last_got, 640);

      // Reset in the middle of a drain, at word 3 of 10
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int l = 0; l < BW; l++) beat_buf[l] = 8'($urandom_range(0, 255));
         push_beat(1'b0);
      end
      drain_only();
      acc    = 0;
      budget = 0;
      out_ready = 1'b1;
      while (acc < 3 && budget < 100) begin
         if (out_valid) acc++;
         tick();
         budget++;
      end
      out_ready = 1'b0;
      check("mid_accepted", acc, 3);
      rst_n = 1'b0;
      tick();
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_drain_done", drain_done, 1'b0);
      rst_n = 1'b1;
      model_clear();
      drain_only();
      collect(-1);
      check("mid_rst_empty", last_got, 0);

      // Randomized rounds with idle gaps and random backpressure
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(0, 40);
         d = 1'($urandom_range(0, 1));
         for (int k = 0; k < n; k++) begin
            for (int l = 0; l < BW; l++) beat_buf[l] = 8'($urandom_range(0, 255));
            push_beat(d && (k == n - 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
         end
         if (!(d && n > 0)) drain_only();
         collect($urandom_range(0, 20));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
